// File: rtl/div32s_radix2_seq.sv
// Sequential signed divider: radix-2 restoring iteration on magnitudes, then sign fixup.
// Optional DIV_EARLY_OUT_EN: zero-divisor and overflow cases bypass CALC.
module div32s_radix2_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow,
  output logic [1:0]       dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready; the
  // producer holds data stable while valid is high and ready is low.

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    LAST     = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] orig_q, orig_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dz_q, dz_d;
  logic             ov_q, ov_d;

  logic [WIDTH-1:0] abs_a, abs_b, rem_trial;
  logic [WIDTH:0]   shifted;
  logic             trial_ok, in_zero, in_ovf;

  // quo_q starts as |dividend| and fills with quotient bits as it shifts out.
  always_comb begin
    abs_a     = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
    abs_b     = divisor[WIDTH-1] ? (~divisor + 1'b1) : divisor;
    in_zero   = (divisor == '0);
    in_ovf    = (dividend == MOST_NEG) && (divisor == '1);
    shifted   = {rem_q, quo_q[WIDTH-1]};
    trial_ok  = (shifted >= {1'b0, dvs_q});
    rem_trial = shifted[WIDTH-1:0] - dvs_q;
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    orig_d      = orig_q;
    neg_a_d     = neg_a_q;
    neg_b_d     = neg_b_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dz_d        = dz_q;
    ov_d        = ov_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          quo_d   = abs_a;
          dvs_d   = abs_b;
          orig_d  = dividend;
          neg_a_d = dividend[WIDTH-1];
          neg_b_d = divisor[WIDTH-1];
          zero_d  = in_zero;
          ovf_d   = in_ovf;
          rem_d   = '0;
          cnt_d   = '0;
`ifdef DIV_EARLY_OUT_EN
          state_d = (in_zero || in_ovf) ? FIX : CALC;
`else
          state_d = CALC;
`endif
        end
      end
      CALC: begin
        rem_d = trial_ok ? rem_trial : shifted[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], trial_ok};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        out_valid_d = 1'b1;
        state_d     = DONE;
        if (zero_q) begin
          quotient_d  = '1;
          remainder_d = orig_q;
          dz_d        = 1'b1;
          ov_d        = 1'b0;
        end else if (ovf_q) begin
          quotient_d  = MOST_NEG;
          remainder_d = '0;
          dz_d        = 1'b0;
          ov_d        = 1'b1;
        end else begin
          quotient_d  = (neg_a_q ^ neg_b_q) ? (~quo_q + 1'b1) : quo_q;
          remainder_d = neg_a_q ? (~rem_q + 1'b1) : rem_q;
          dz_d        = 1'b0;
          ov_d        = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      orig_q      <= '0;
      neg_a_q     <= 1'b0;
      neg_b_q     <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dz_q        <= 1'b0;
      ov_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      orig_q      <= orig_d;
      neg_a_q     <= neg_a_d;
      neg_b_q     <= neg_b_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dz_q        <= dz_d;
      ov_q        <= ov_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dz_q;
  assign overflow    = ov_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_div32s_radix2_seq.sv
// Bench for div32s_radix2_seq: directed and random operands checked against an
// arithmetic reference model through an expected-result queue.
module tb_div32s_radix2_seq;
  localparam int W  = 32;
  localparam int EW = 2 * W + 3;

  logic         clk = 1'b0;
  logic         rst, in_valid, out_ready;
  logic [W-1:0] dividend, divisor;
  logic         in_ready, out_valid, div_by_zero, overflow;
  logic [W-1:0] quotient, remainder;
  logic [1:0]   dbg_state;

  div32s_radix2_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0, done_cnt = 0;
  logic [EW-1:0] exp_q[$];
  int            acc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference: signed 64-bit arithmetic, truncating division, special cases first.
  function automatic logic [EW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    longint       sa, sb, q, r;
    logic [W-1:0] qv, rv;
    logic         dz, ov, lat_en;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = (b == 0);
    ov = (sa == -longint'(64'd2147483648)) && (sb == -1);
    if (dz) begin
      qv = '1;
      rv = a;
    end else if (ov) begin
      qv = 32'h8000_0000;
      rv = '0;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      qv = q[W-1:0];
      rv = r[W-1:0];
    end
`ifdef DIV_EARLY_OUT_EN
    lat_en = !(dz || ov);
`else
    lat_en = 1'b1;
`endif
    return {lat_en, dz, ov, qv, rv};
  endfunction

  // Monitor: idle/busy invariants, latency, stability under stall, result compare.
  logic         prev_valid = 1'b0;
  logic [W-1:0] hold_q, hold_r;
  logic         hold_dz, hold_ov;
  logic [EW-1:0] e;
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (exp_q.size() == 0) chk("no_stale_valid", {31'd0, out_valid}, 32'd0);
      else chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
      if (out_valid && exp_q.size() > 0) begin
        e = exp_q[0];
        if (!prev_valid) begin
          if (e[2*W+2]) chk("latency", W'(cyc - acc_q[0]), W'(W + 1));
        end else begin
          chk("stall_quotient", quotient, hold_q);
          chk("stall_remainder", remainder, hold_r);
          chk("stall_flags", {30'd0, div_by_zero, overflow}, {30'd0, hold_dz, hold_ov});
        end
        hold_q  = quotient;
        hold_r  = remainder;
        hold_dz = div_by_zero;
        hold_ov = overflow;
        if (out_ready) begin
          chk("quotient", quotient, e[2*W-1:W]);
          chk("remainder", remainder, e[W-1:0]);
          chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e[2*W+1]});
          chk("overflow", {31'd0, overflow}, {31'd0, e[2*W]});
          void'(exp_q.pop_front());
          void'(acc_q.pop_front());
          done_cnt++;
        end
      end
      prev_valid = out_valid;
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout actual=busy required=in_ready");
      return;
    end
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    exp_q.push_back(model(a, b));
    acc_q.push_back(cyc);
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  task automatic wait_done(input bit rand_rdy);
    int start = done_cnt;
    int n = 0;
    while (done_cnt == start && n < 300) begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
      n++;
    end
    if (done_cnt == start) begin
      checks++;
      failures++;
      $display("FAIL result_timeout actual=none required=result");
    end
    out_ready = 1'b1;
  endtask

  logic [W-1:0] da[12] = '{32'd100, 32'hFFFF_FF9C, 32'd100, 32'hFFFF_FF9C,
                           32'h8000_0000, 32'h8000_0000, 32'd1234, 32'hFFFF_FFFB,
                           32'd0, 32'h7FFF_FFFF, 32'd5, 32'h8000_0000};
  logic [W-1:0] db[12] = '{32'd7, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                           32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0,
                           32'd5, 32'd1, 32'h8000_0000, 32'h8000_0000};

  initial begin
    logic [W-1:0] a, b;
    int n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_flags", {30'd0, div_by_zero, overflow}, 32'd0);
    rst = 1'b0;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 12; i++) begin
      issue(da[i], db[i]);
      wait_done(1'b0);
    end

    // Backpressure: 500 / 9 = 55 r 5 held for ten cycles, then one-cycle accept.
    out_ready = 1'b0;
    issue(32'd500, 32'd9);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", {31'd0, out_valid}, 32'd1);
    repeat (10) @(negedge clk);
    @(posedge clk); #1; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk("bp_valid_cleared", {31'd0, out_valid}, 32'd0);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_quotient_kept", quotient, 32'd55);
    chk("bp_remainder_kept", remainder, 32'd5);
    issue(32'd7, 32'd3);
    out_ready = 1'b1;
    wait_done(1'b0);

    // Reset during the 15th CALC cycle; the aborted result must never appear.
    issue(32'h1234_5678, 32'd3);
    repeat (14) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    acc_q.delete();
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_quotient", quotient, 32'd0);
    chk("abort_remainder", remainder, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue(32'h7FFF_FFFF, 32'h10);
    wait_done(1'b0);

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      case ($urandom_range(0, 5))
        0: b = '0;
        1: begin
          b = $urandom_range(1, 20);
          if ($urandom_range(0, 1) == 1) b = -b;
        end
        2: b = '1;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      issue(a, b);
      wait_done(1'b1);
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", W'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
